ce_wrap_counter: RTL and testbench

Clock-enabled state counter. Each enabled cycle it steps down by one. Leaving the wrap state jumps back to a configurable high state, giving a repeating 14→5 loop for the default 4-bit configuration. It is built from a D flip-flop register stage and a two-input enable switch. It sits in the digital-circuit exercise designs as the reusable "state register + next-state + enable" datapath, and exposes its internal nodes for logging.

---
 rtl/ce_wrap_pkg.sv | 38 +++
 rtl/ce_switch.sv | 32 +++
 rtl/state_dff.sv | 34 +++
 rtl/ce_wrap_counter.sv | 88 ++++++++
 tb/tb_ce_wrap_counter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ce_wrap_pkg.sv
// ---------------------------------------------------------------------------
// ce_wrap_pkg
// Shared definitions for the clock-enabled wrap counter:
//   CW_WIDTH      default state width
//   CW_WRAP_FROM  state whose successor is CW_WRAP_TO instead of a decrement
//   CW_WRAP_TO    successor of CW_WRAP_FROM (top of the repeating loop)
//   CW_RESET_VAL  value forced by the asynchronous reset
//   state_t       state word of CW_WIDTH bits
//   next_state()  decrement-with-wrap successor function
// ---------------------------------------------------------------------------
package ce_wrap_pkg;

    localparam int CW_WIDTH = 4;

    typedef logic [CW_WIDTH-1:0] state_t;

    localparam state_t CW_WRAP_FROM = 4'd5;
    localparam state_t CW_WRAP_TO   = 4'd14;
    localparam state_t CW_RESET_VAL = 4'd0;

    // The wrap pair defaults to the package constants so the common call is
    // next_state(s); a top with overridden wrap points passes its own pair.
    function automatic state_t next_state(
        input state_t s,
        input state_t wrap_from = CW_WRAP_FROM,
        input state_t wrap_to   = CW_WRAP_TO
    );
        state_t w_next;
        if (s == wrap_from) begin
            w_next = wrap_to;
        end else begin
            // Unsigned subtraction: 0 rolls over to all-ones.
            w_next = s - state_t'(1);
        end
        return w_next;
    endfunction

endpackage : ce_wrap_pkg

// File: rtl/ce_switch.sv
// ---------------------------------------------------------------------------
// ce_switch
// Two-input enable switch used as the hold/advance selector.
// Ports:
//   CE    in   1      select: 1 = IN_2, 0 = IN_1
//   IN_1  in   WIDTH  value passed when CE = 0 (hold path)
//   IN_2  in   WIDTH  value passed when CE = 1 (advance path)
//   OUT   out  WIDTH  selected value
// ---------------------------------------------------------------------------
module ce_switch
    import ce_wrap_pkg::*;
#(
    parameter int WIDTH = CW_WIDTH
) (
    input  logic             CE,
    input  logic [WIDTH-1:0] IN_1,
    input  logic [WIDTH-1:0] IN_2,
    output logic [WIDTH-1:0] OUT
);

    logic [WIDTH-1:0] w_out;

    always_comb begin
        w_out = IN_1;
        if (CE) begin
            w_out = IN_2;
        end
    end

    assign OUT = w_out;

endmodule : ce_switch

// File: rtl/state_dff.sv
// ---------------------------------------------------------------------------
// state_dff
// Word-wide D flip-flop holding the counter state.
// Ports:
//   RST  in   1      asynchronous active-low reset, loads RESET_VAL
//   CLK  in   1      rising-edge capture clock
//   IN   in   WIDTH  D input
//   OUT  out  WIDTH  registered value
// ---------------------------------------------------------------------------
module state_dff
    import ce_wrap_pkg::*;
#(
    parameter int               WIDTH     = CW_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(CW_RESET_VAL)
) (
    input  logic             RST,
    input  logic             CLK,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] OUT
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= IN;
        end
    end

    assign OUT = r_q;

endmodule : state_dff

// File: rtl/ce_wrap_counter.sv
// ---------------------------------------------------------------------------
// ce_wrap_counter
// Clock-enabled down counter with a wrap jump: each enabled cycle the state
// decrements, except WRAP_FROM which jumps to WRAP_TO, giving 14..5 looping
// for the default configuration. Internal nodes are exposed for logging.
// Ports:
//   CLK            in   1      rising-edge clock
//   RST            in   1      asynchronous active-low reset (VAL = RESET_VAL)
//   CE             in   1      1 = advance, 0 = hold
//   LOAD           in   1      synchronous load of IN, overrides CE
//   IN             in   WIDTH  load value
//   VAL            out  WIDTH  registered state
//   LOG_LOGIC      out  WIDTH  successor of VAL (decrement / wrap)
//   LOG_SWITCHING  out  WIDTH  D input of the state register
// ---------------------------------------------------------------------------
module ce_wrap_counter
    import ce_wrap_pkg::*;
#(
    parameter int               WIDTH     = CW_WIDTH,
    parameter logic [WIDTH-1:0] WRAP_FROM = WIDTH'(CW_WRAP_FROM),
    parameter logic [WIDTH-1:0] WRAP_TO   = WIDTH'(CW_WRAP_TO),
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(CW_RESET_VAL)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] VAL,
    output logic [WIDTH-1:0] LOG_LOGIC,
    output logic [WIDTH-1:0] LOG_SWITCHING
);

    logic [WIDTH-1:0] w_val;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_switch;
    logic [WIDTH-1:0] w_d;

    // The package function is typed on the default width; other widths use
    // the same rule written out at WIDTH bits.
    generate
        if (WIDTH == CW_WIDTH) begin : g_pkg_next
            always_comb begin
                w_logic = next_state(state_t'(w_val), state_t'(WRAP_FROM),
                                     state_t'(WRAP_TO));
            end
        end else begin : g_generic_next
            always_comb begin
                w_logic = w_val - WIDTH'(1);
                if (w_val == WRAP_FROM) begin
                    w_logic = WRAP_TO;
                end
            end
        end
    endgenerate

    ce_switch #(
        .WIDTH (WIDTH)
    ) u_switch (
        .CE   (CE),
        .IN_1 (w_val),
        .IN_2 (w_logic),
        .OUT  (w_switch)
    );

    // Load sits after the enable switch so it wins even when CE = 0.
    always_comb begin
        w_d = w_switch;
        if (LOAD) begin
            w_d = IN;
        end
    end

    state_dff #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_state (
        .RST (RST),
        .CLK (CLK),
        .IN  (w_d),
        .OUT (w_val)
    );

    assign VAL           = w_val;
    assign LOG_LOGIC     = w_logic;
    assign LOG_SWITCHING = w_d;

endmodule : ce_wrap_counter

// File: tb/tb_ce_wrap_counter.sv
module tb_ce_wrap_counter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CE;
    logic       LOAD;
    logic [3:0] IN;
    logic [3:0] VAL;
    logic [3:0] LOG_LOGIC;
    logic [3:0] LOG_SWITCHING;

    logic       sw_ce;
    logic [3:0] sw_in1;
    logic [3:0] sw_in2;
    logic [3:0] sw_out;

    logic       d_rst;
    logic [3:0] d_in;
    logic [3:0] d_out;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    ce_wrap_counter dut (
        .CLK           (CLK),
        .RST           (RST),
        .CE            (CE),
        .LOAD          (LOAD),
        .IN            (IN),
        .VAL           (VAL),
        .LOG_LOGIC     (LOG_LOGIC),
        .LOG_SWITCHING (LOG_SWITCHING)
    );

    ce_switch #(.WIDTH(4)) u_sw (
        .CE   (sw_ce),
        .IN_1 (sw_in1),
        .IN_2 (sw_in2),
        .OUT  (sw_out)
    );

    state_dff #(.WIDTH(4), .RESET_VAL(4'd0)) u_dff (
        .RST (d_rst),
        .CLK (CLK),
        .IN  (d_in),
        .OUT (d_out)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] exp_run  [14];
    logic [3:0] exp_tail [4];

    initial begin
        exp_run  = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9,
                     4'd8,  4'd7,  4'd6,  4'd5,  4'd14, 4'd13, 4'd12};
        exp_tail = '{4'd1, 4'd0, 4'd15, 4'd14};

        RST = 1'b0; CE = 1'b1; LOAD = 1'b1; IN = 4'd7;
        sw_ce = 1'b0; sw_in1 = 4'd3; sw_in2 = 4'd12;
        d_rst = 1'b0; d_in = 4'd0;

        // Reset without any clock edge
        #3;
        chk("reset_val",       VAL,           4'd0);
        chk("reset_logic",     LOG_LOGIC,     4'd15);
        chk("reset_switching", LOG_SWITCHING, 4'd7);
        chk("dff_reset",       d_out,         4'd0);
        tick();
        chk("reset_held_edge", VAL,           4'd0);

        LOAD = 1'b0; IN = 4'd0;
        #1;
        chk("reset_switch_ce", LOG_SWITCHING, 4'd15);
        RST = 1'b1;

        // Free run through the wrap
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("run_logic_%0d", i), LOG_LOGIC, exp_run[i]);
            tick();
            chk($sformatf("run_val_%0d", i), VAL, exp_run[i]);
        end

        tick(); chk("to9_a", VAL, 4'd11);
        tick(); chk("to9_b", VAL, 4'd10);
        tick(); chk("to9_c", VAL, 4'd9);

        // Hold
        CE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold_val_%0d", i),   VAL,           4'd9);
            chk($sformatf("hold_sw_%0d", i),    LOG_SWITCHING, 4'd9);
            chk($sformatf("hold_logic_%0d", i), LOG_LOGIC,     4'd8);
        end
        CE = 1'b1;
        tick();
        chk("reenable", VAL, 4'd8);

        // Load WRAP_FROM with CE=1
        LOAD = 1'b1; IN = 4'd5;
        #1;
        chk("load5_switching", LOG_SWITCHING, 4'd5);
        tick();
        chk("load5_val", VAL, 4'd5);
        LOAD = 1'b0;
        #1;
        chk("load5_logic", LOG_LOGIC, 4'd14);
        tick();
        chk("after_load5", VAL, 4'd14);

        // Load a value below the loop and follow it round through zero
        LOAD = 1'b1; IN = 4'd2;
        tick();
        chk("load2_val", VAL, 4'd2);
        LOAD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("tail_%0d", i), VAL, exp_tail[i]);
        end

        // Load wins over CE=0
        CE = 1'b0; LOAD = 1'b1; IN = 4'd11;
        tick();
        chk("load_ce0", VAL, 4'd11);
        LOAD = 1'b0;
        tick();
        chk("hold_after_load", VAL, 4'd11);
        CE = 1'b1;

        // Async reset between edges
        #2;
        RST = 1'b0;
        #1;
        chk("async_val",   VAL,       4'd0);
        chk("async_logic", LOG_LOGIC, 4'd15);
        LOAD = 1'b1; IN = 4'd9;
        tick();
        chk("async_ignore_load", VAL, 4'd0);
        LOAD = 1'b0;
        RST = 1'b1;
        tick();
        chk("resume_15", VAL, 4'd15);
        tick();
        chk("resume_14", VAL, 4'd14);

        // ce_switch unit
        #1;
        chk("sw_ce0", sw_out, 4'd3);
        sw_ce = 1'b1;
        #1;
        chk("sw_ce1", sw_out, 4'd12);

        // state_dff unit
        d_rst = 1'b1; d_in = 4'hA;
        #1;
        chk("dff_no_edge", d_out, 4'd0);
        tick();
        chk("dff_capture", d_out, 4'hA);
        d_in = 4'd3;
        #2;
        chk("dff_hold_between", d_out, 4'hA);
        d_rst = 1'b0;
        #1;
        chk("dff_async_clear", d_out, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ce_wrap_counter
